// File: rtl/debounce_trigger_bank.sv
// Multi-channel synchronise/debounce bank with mode-selected edge pulses.
// Optional auto-repeat pulses while a debounced level stays high.
module debounce_trigger_bank #(
    parameter int CHANNELS      = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_COUNT  = 3,
    parameter int REPEAT_PERIOD = 0
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [CHANNELS-1:0] in,
    input  logic [1:0]          mode,
    input  logic                repeat_en,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] pulse,
    output logic                any_pulse
);
    localparam int CW = (STABLE_COUNT > 1) ? $clog2(STABLE_COUNT) : 1;
    localparam logic [CW-1:0] CMAX = CW'(STABLE_COUNT - 1);

    logic [CHANNELS-1:0][SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CHANNELS-1:0][CW-1:0]          cnt_q, cnt_d;
    logic [CHANNELS-1:0]                  level_q, level_d;
    logic [CHANNELS-1:0]                  pulse_q, pulse_d;
    logic [CHANNELS-1:0]                  rep_pulse;
    logic                                 want_rise, want_fall, mode_none;

    always_comb begin
        want_rise = 1'b0;
        want_fall = 1'b0;
        mode_none = 1'b0;
        unique case (mode)
            2'b00:   want_rise = 1'b1;
            2'b01:   want_fall = 1'b1;
            2'b10: begin
                want_rise = 1'b1;
                want_fall = 1'b1;
            end
            default: mode_none = 1'b1;
        endcase
    end

    always_comb begin
        sync_d  = sync_q;
        cnt_d   = '0;
        level_d = level_q;
        pulse_d = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            sync_d[c] = {sync_q[c][SYNC_STAGES-2:0], in[c]};
            // Counter only survives while the synchronised input disagrees
            if (sync_q[c][SYNC_STAGES-1] != level_q[c]) begin
                if (cnt_q[c] == CMAX) begin
                    level_d[c] = sync_q[c][SYNC_STAGES-1];
                    pulse_d[c] = level_q[c] ? want_fall : want_rise;
                end else begin
                    cnt_d[c] = cnt_q[c] + 1'b1;
                end
            end
            pulse_d[c] = pulse_d[c] | (rep_pulse[c] & ~mode_none);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= '0;
            pulse_q <= '0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
        end
    end

    generate
        if (REPEAT_PERIOD > 0) begin : g_rep
            localparam int RW = (REPEAT_PERIOD > 1) ? $clog2(REPEAT_PERIOD) : 1;
            localparam logic [RW-1:0] RMAX = RW'(REPEAT_PERIOD - 1);

            logic [CHANNELS-1:0][RW-1:0] rcnt_q, rcnt_d;

            always_comb begin
                rcnt_d    = '0;
                rep_pulse = '0;
                for (int c = 0; c < CHANNELS; c++) begin
                    // level_q is still 0 on the rise edge, so that edge clears too
                    if (level_q[c] && repeat_en) begin
                        if (rcnt_q[c] == RMAX) begin
                            rep_pulse[c] = 1'b1;
                        end else begin
                            rcnt_d[c] = rcnt_q[c] + 1'b1;
                        end
                    end
                end
            end

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    rcnt_q <= '0;
                end else begin
                    rcnt_q <= rcnt_d;
                end
            end
        end else begin : g_norep
            assign rep_pulse = '0;
        end
    endgenerate

    assign level     = level_q;
    assign pulse     = pulse_q;
    assign any_pulse = |pulse_q;

endmodule

// File: tb/tb_debounce_trigger_bank.sv
// Bench for debounce_trigger_bank: directed scenarios plus random stimulus
// checked against a sample-window reference model.
`timescale 1ns/1ps
module tb_debounce_trigger_bank;
    localparam int CH = 4;
    localparam int SS = 2;
    localparam int SC = 3;
    localparam int P  = 4;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic [CH-1:0] din = '0;
    logic [1:0]    mode = 2'b00;
    logic          repeat_en = 1'b0;
    logic [CH-1:0] level, pulse;
    logic          any_pulse;

    int tests = 0;
    int fails = 0;

    logic [CH-1:0] ihist[$];
    int            base = 0;
    int            last_clear[CH];
    logic [CH-1:0] m_level = '0;
    logic [CH-1:0] m_pulse = '0;

    debounce_trigger_bank #(
        .CHANNELS(CH), .SYNC_STAGES(SS),
        .STABLE_COUNT(SC), .REPEAT_PERIOD(P)
    ) dut (
        .clock(clock), .reset_n(reset_n), .in(din),
        .mode(mode), .repeat_en(repeat_en),
        .level(level), .pulse(pulse), .any_pulse(any_pulse)
    );

    always #20 clock = ~clock;

    initial begin
        #1ms;
        $display("FAIL watchdog timeout tests=%0d", tests);
        $fatal(1);
    end

    // Level flips once the last SC synchronised samples (input delayed by
    // SS edges) all disagree with it; repeats fire every P edges after the
    // most recent edge where level was low or repeat was disabled.
    task automatic tick();
        int kk, idx;
        logic [CH-1:0] nl, np, h;
        bit flip, ep, rp;
        @(posedge clock);
        ihist.push_back(din);
        kk = ihist.size() - 1;
        nl = m_level;
        np = '0;
        for (int c = 0; c < CH; c++) begin
            flip = (kk - SC + 1 >= base);
            for (int j = 0; j < SC; j++) begin
                idx = kk - j - SS;
                h = (idx >= base) ? ihist[idx] : '0;
                if (h[c] == m_level[c]) flip = 0;
            end
            ep = flip && ((mode == 2'b00 && !m_level[c]) ||
                          (mode == 2'b01 && m_level[c]) ||
                          (mode == 2'b10));
            rp = 0;
            if (!m_level[c] || !repeat_en) last_clear[c] = kk;
            else rp = ((kk - last_clear[c]) % P) == 0;
            np[c] = ep || (rp && mode != 2'b11);
            if (flip) nl[c] = ~m_level[c];
        end
        m_level = nl;
        m_pulse = np;
        #1;
    endtask

    task automatic settle(input int n);
        din = '0;
        repeat_en = 1'b0;
        repeat (n) tick();
    endtask

    task automatic assert_reset();
        reset_n = 1'b0;
        m_level = '0;
        m_pulse = '0;
    endtask

    task automatic release_reset();
        @(negedge clock);
        reset_n = 1'b1;
        base = ihist.size();
        for (int c = 0; c < CH; c++) last_clear[c] = base - 1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clock);
        #1;
        tests++;
        if (level !== 4'b0 || pulse !== 4'b0 || any_pulse !== 1'b0) begin
            fails++;
            $display("FAIL reset_state level=%b pulse=%b any=%b want 0",
                     level, pulse, any_pulse);
        end
        din = 4'b0100;
        release_reset();
        for (int i = 1; i <= 8; i++) begin
            tick();
            tests++;
            if (level[2] !== (i >= 5) || pulse[2] !== (i == 5)) begin
                fails++;
                $display("FAIL held_thru_reset i=%0d level=%b pulse=%b",
                         i, level[2], pulse[2]);
            end
        end
    endtask

    task automatic test_rising();
        settle(10);
        mode = 2'b00;
        din[0] = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            tests++;
            if (level[0] !== (i >= 5) || pulse[0] !== (i == 5) ||
                level !== m_level || pulse !== m_pulse) begin
                fails++;
                $display("FAIL rising i=%0d level=%b pulse=%b want %b/%b",
                         i, level, pulse, m_level, m_pulse);
            end
        end
        din[0] = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            tests++;
            if (pulse[0] !== 1'b0 || level[0] !== (i < 5)) begin
                fails++;
                $display("FAIL falling_rmode i=%0d level=%b pulse=%b",
                         i, level[0], pulse[0]);
            end
        end
    endtask

    task automatic test_glitch();
        int lens[3] = '{1, 2, 6};
        settle(10);
        mode = 2'b10;
        for (int g = 0; g < 3; g++) begin
            din[1] = 1'b1;
            for (int i = 1; i <= lens[g]; i++) begin
                tick();
                tests++;
                if (level !== m_level || pulse !== m_pulse) begin
                    fails++;
                    $display("FAIL glitch_model g=%0d level=%b/%b pulse=%b/%b",
                             g, level, m_level, pulse, m_pulse);
                end
            end
            din[1] = 1'b0;
            for (int i = 1; i <= 6; i++) begin
                tick();
                tests++;
                if (g < 2 && (level[1] !== 1'b0 || pulse[1] !== 1'b0)) begin
                    fails++;
                    $display("FAIL glitch_absorb g=%0d level=%b pulse=%b",
                             g, level[1], pulse[1]);
                end
            end
        end
        tests++;
        if (m_level[1] !== 1'b0 || level[1] !== 1'b0) begin
            fails++;
            $display("FAIL glitch_final level=%b want 0", level[1]);
        end
    endtask

    task automatic test_both_none();
        int hits[$];
        int hi;
        for (int m = 0; m < 2; m++) begin
            settle(10);
            mode = (m == 0) ? 2'b10 : 2'b11;
            hits.delete();
            hi = 0;
            for (int i = 1; i <= 16; i++) begin
                din[2] = (i <= 8);
                tick();
                if (pulse[2]) hits.push_back(i);
                if (level[2]) hi++;
            end
            tests++;
            if (m == 0 && (hits.size() != 2 || hits[0] != 5 || hits[1] != 13)) begin
                fails++;
                $display("FAIL mode_both pulses=%0d first=%0d want 2 at 5,13",
                         hits.size(), hits.size() > 0 ? hits[0] : -1);
            end
            if (m == 1 && (hits.size() != 0 || hi != 8)) begin
                fails++;
                $display("FAIL mode_none pulses=%0d high_cycles=%0d want 0,8",
                         hits.size(), hi);
            end
        end
    endtask

    task automatic test_repeat();
        int hits[$];
        int want_on[5] = '{5, 9, 13, 17, 21};
        for (int r = 0; r < 2; r++) begin
            settle(10);
            mode = 2'b00;
            repeat_en = (r == 0);
            din[3] = 1'b1;
            hits.delete();
            for (int i = 1; i <= 24; i++) begin
                tick();
                if (pulse[3]) hits.push_back(i);
                tests++;
                if (pulse !== m_pulse || level !== m_level) begin
                    fails++;
                    $display("FAIL repeat_model i=%0d pulse=%b want %b", i, pulse, m_pulse);
                end
            end
            tests++;
            if (r == 0) begin
                if (hits.size() != 5) begin
                    fails++;
                    $display("FAIL repeat_on count=%0d want 5", hits.size());
                end else begin
                    for (int k = 0; k < 5; k++)
                        if (hits[k] != want_on[k]) begin
                            fails++;
                            $display("FAIL repeat_on idx=%0d at=%0d want %0d",
                                     k, hits[k], want_on[k]);
                        end
                end
            end else if (hits.size() != 1 || hits[0] != 5) begin
                fails++;
                $display("FAIL repeat_off count=%0d want 1 at 5", hits.size());
            end
        end
    endtask

    task automatic test_simultaneous();
        settle(10);
        mode = 2'b00;
        din = 4'b1001;
        for (int i = 1; i <= 8; i++) begin
            tick();
            tests++;
            if (pulse !== ((i == 5) ? 4'b1001 : 4'b0000) || any_pulse !== (i == 5)) begin
                fails++;
                $display("FAIL simultaneous i=%0d pulse=%b any=%b", i, pulse, any_pulse);
            end
        end
    endtask

    task automatic test_reset_mid();
        settle(10);
        mode = 2'b00;
        din = 4'b0010;
        repeat (6) tick();
        din = 4'b0011;
        repeat (2) tick();
        assert_reset();
        #2;
        tests++;
        if (level !== 4'b0 || pulse !== 4'b0 || any_pulse !== 1'b0) begin
            fails++;
            $display("FAIL reset_async level=%b pulse=%b any=%b want 0",
                     level, pulse, any_pulse);
        end
        @(posedge clock);
        release_reset();
        for (int i = 1; i <= 8; i++) begin
            tick();
            tests++;
            if (level !== ((i >= 5) ? 4'b0011 : 4'b0000) ||
                pulse !== ((i == 5) ? 4'b0011 : 4'b0000)) begin
                fails++;
                $display("FAIL reset_mid i=%0d level=%b pulse=%b", i, level, pulse);
            end
        end
    endtask

    task automatic test_random();
        int rst_at = $urandom_range(150, 350);
        settle(10);
        for (int i = 0; i < 500; i++) begin
            for (int c = 0; c < CH; c++)
                if ($urandom_range(0, 5) == 0) din[c] = ~din[c];
            if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 29) == 0) repeat_en = ~repeat_en;
            if (i == rst_at) begin
                assert_reset();
                @(posedge clock);
                release_reset();
            end
            tick();
            tests++;
            if (level !== m_level || pulse !== m_pulse || any_pulse !== (|m_pulse)) begin
                fails++;
                $display("FAIL random i=%0d level=%b/%b pulse=%b/%b any=%b",
                         i, level, m_level, pulse, m_pulse, any_pulse);
            end
        end
    endtask

    initial begin
        for (int c = 0; c < CH; c++) last_clear[c] = -1;
        test_reset();
        test_rising();
        test_glitch();
        test_both_none();
        test_repeat();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
